// File: rtl/cpu_pkg.sv
// cpu_pkg - shared definitions for the fetch/execute sequencer.
//   Default bus widths, instruction opcodes, the sequencer state
//   encoding and a small opcode classification helper.
package cpu_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALTED
    } state_t;

    // LOAD and STORE are the only opcodes that need an operand bus phase.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if - memory request/acknowledge bus between the
// sequencer and the memory/bus interface.
//   mem_req   : request, held until acknowledged (master -> slave)
//   mem_we    : write strobe, valid while mem_req=1 (master -> slave)
//   mem_wdata : store data (master -> slave)
//   mem_ack   : current request completes this cycle (slave -> master)
//   mem_rdata : read data, valid with mem_ack (slave -> master)
interface fetch_sequencer_if #(
    parameter int DATA_W = cpu_pkg::DATA_W_DEF
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/pc_reg.sv
// pc_reg - program counter with synchronous reset, load and increment.
//   clk      : system clock
//   rst      : synchronous active-high reset, loads RESET_PC
//   inc      : advance the PC by PC_INC (wraps modulo 2^ADDR_W)
//   load     : load load_val (jump target); wins over inc
//   load_val : jump target
//   pc       : current program counter
module pc_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PC_INC   = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            // Natural truncation to ADDR_W gives the modulo wrap.
            pc <= pc + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer - instruction fetch/execute sequencer for the RISC core.
//   clk, rst    : system clock, synchronous active-high reset
//   run         : start enable, sampled in IDLE
//   fetch       : 1 = memory address is pcout, 0 = memory address is irout
//   pcout       : program counter
//   irout       : IR operand address field
//   opcode      : IR opcode field
//   bus         : memory request/ack bus (master side)
//   store_data  : value written by STORE
//   load_data   : last LOAD result
//   load_valid  : one-cycle pulse when load_data updates
//   halted      : high in HALTED
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for run
// ST_FETCH  | instruction read at pcout, held until mem_ack
// ST_DECODE | one cycle; dispatch on opcode, JMP loads the PC here
// ST_EXEC   | LOAD/STORE operand access at irout, held until mem_ack
// ST_HALTED | parked until reset
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PC_INC   = 1,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 fetch,
    output logic [ADDR_W-1:0]    pcout,
    output logic [ADDR_W-1:0]    irout,
    output logic [3:0]           opcode,
    fetch_sequencer_if.master    bus,
    input  logic [DATA_W-1:0]    store_data,
    output logic [DATA_W-1:0]    load_data,
    output logic                 load_valid,
    output logic                 halted
);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] ir;
    logic              pc_inc;
    logic              pc_load;
    logic              fetch_done;
    logic              exec_done;

    assign irout  = ir[ADDR_W-1:0];
    assign opcode = ir[DATA_W-1 -: 4];

    // Acks only count in the two requesting states; elsewhere they are ignored.
    assign fetch_done = (state == ST_FETCH) && bus.mem_ack;
    assign exec_done  = (state == ST_EXEC) && bus.mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ack) begin
                    pc_inc   = 1'b1;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_mem_op(opcode)) begin
                    state_nx = ST_EXEC;
                end else begin
                    case (opcode)
                        OP_JMP: begin
                            pc_load  = 1'b1;
                            state_nx = ST_FETCH;
                        end
                        OP_HALT: state_nx = ST_HALTED;
                        OP_NOP:  state_nx = ST_FETCH;
                        default: state_nx = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC: begin
                if (bus.mem_ack) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_HALTED: state_nx = ST_HALTED;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir         <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            if (fetch_done) begin
                ir <= bus.mem_rdata;
            end
            load_valid <= exec_done && (opcode == OP_LOAD);
            if (exec_done && (opcode == OP_LOAD)) begin
                load_data <= bus.mem_rdata;
            end
        end
    end

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .PC_INC   (PC_INC),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (irout),
        .pc       (pcout)
    );

    // Outputs decode straight from the state register so they stay
    // constant for the whole of a request, however long the memory waits.
    assign fetch         = (state == ST_FETCH) || (state == ST_DECODE);
    assign bus.mem_req   = (state == ST_FETCH) || (state == ST_EXEC);
    assign bus.mem_we    = (state == ST_EXEC) && (opcode == OP_STORE);
    assign bus.mem_wdata = bus.mem_we ? store_data : '0;
    assign halted        = (state == ST_HALTED);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch/execute sequencer for the 32-bit RISC core.
- Generates the `fetch` select and holds the `pcout`/`irout` values that the existing address multiplexer combines into the 28-bit memory address.
- Runs the memory request/acknowledge handshake for instruction fetch and for load/store operand access.
- Sits between the address multiplexer and the memory/bus interface.

Parameters:
- ADDR_W, 28, width of PC, IR address field and memory address.
- DATA_W, 32, instruction/data word width.
- PC_INC, 1, PC increment per fetched instruction (word addressing).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- run  input  1  start enable, sampled in IDLE.
- fetch  output  1  1 = memory address is the PC (instruction phase); 0 = memory address is the IR address field.
- pcout  output  ADDR_W  program counter.
- irout  output  ADDR_W  IR[27:0], the operand address field.
- opcode  output  4  IR[31:28].
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  write strobe, valid while mem_req=1.
- mem_wdata  output  DATA_W  store data, equal to store_data while mem_we=1, else 0.
- mem_ack  input  1  memory completes the current request this cycle.
- mem_rdata  input  DATA_W  read data, valid when mem_ack=1.
- store_data  input  DATA_W  value written by STORE.
- load_data  output  DATA_W  last LOAD result.
- load_valid  output  1  one-cycle pulse when load_data updates.
- halted  output  1  high in HALTED state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst); all registers clear on the clk edge where rst=1.
- Reset values: state=IDLE, pcout=RESET_PC, IR=0 (so irout=0, opcode=0), fetch=0, mem_req=0, mem_we=0, load_data=0, load_valid=0, halted=0.
- Instruction format: [31:28] opcode, [27:0] address.
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 JMP, F HALT. All other opcodes execute as NOP.
- State machine (Moore outputs; fetch, mem_req and mem_we are registered/state-decoded):
  - IDLE: fetch=0, mem_req=0. If run=1, go to FETCH next cycle.
  - FETCH: fetch=1, mem_req=1, mem_we=0. Hold until mem_ack=1. On the ack edge: IR<=mem_rdata, pcout<=pcout+PC_INC, go to DECODE.
  - DECODE (exactly one cycle, mem_req=0, fetch=1):
    - NOP/undefined -> FETCH.
    - JMP -> pcout<=irout, then FETCH.
    - LOAD or STORE -> EXEC.
    - HALT -> HALTED.
  - EXEC: fetch=0, mem_req=1, mem_we=(opcode==STORE). Hold until mem_ack. On the ack edge:
    - LOAD: load_data<=mem_rdata, load_valid=1 for the following cycle only.
    - Then go to FETCH.
  - HALTED: halted=1, mem_req=0, fetch=0. Leaves only via rst; run is ignored.
- Handshake rules:
  - mem_ack is honoured only while mem_req=1; mem_ack in IDLE, DECODE or HALTED is ignored with no state change.
  - mem_ack may arrive in the first cycle of a request.
  - fetch and the IR/PC values are stable for the whole request.
- Latency:
  - Zero-wait-state memory (ack in first request cycle): NOP = 2 cycles/instruction; LOAD/STORE = 3 cycles/instruction.
  - Each wait cycle extends the current phase by 1.
- Arithmetic: PC increment wraps modulo 2^ADDR_W; no overflow flag.
- Reset mid-operation: mem_req drops on the next edge with no further transfer. A pending ack in the reset cycle is ignored.
- Simultaneous events:
  - rst has priority over everything.
  - JMP whose target equals the current pcout still executes normally.

Decomposition:
- Shared package `cpu_pkg`: opcode constants (OP_NOP, OP_LOAD, OP_STORE, OP_JMP, OP_HALT), state encoding enum, ADDR_W/DATA_W defaults.
- One natural sub-module: `pc_reg`, the program counter with load, increment and wrap logic. The state machine stays in the top module.

Test Plan:
- Reset then run=1, zero-wait memory returning 0x00000000 (NOP) -> fetch=1 with pcout 0,1,2 in successive FETCH phases; 2 cycles per instruction; mem_we never set.
- Instr 0x10000040 (LOAD 0x40), data 0xDEADBEEF -> EXEC cycle has fetch=0, irout=0x0000040; load_data=0xDEADBEEF; load_valid high exactly 1 cycle; next pcout=1.
- Instr 0x20000010 (STORE), store_data=0xCAFEF00D, ack delayed 3 cycles -> mem_req/mem_we/mem_wdata held steady 4 cycles; returns to FETCH.
- pcout=0xFFFFFFF, NOP fetched -> pcout wraps to 0x0000000. Instr 0x3000ABCD (JMP) -> next fetch at pcout=0x000ABCD.
- Instr 0xF0000000 (HALT) -> halted=1, mem_req=0; stays halted despite run or mem_ack toggling; rst -> IDLE, pcout=0.
- rst asserted mid-EXEC with mem_ack=1 the same cycle -> no load_valid pulse; all outputs at reset values next cycle.
